rx_unpack: RTL
==============

RX_UNPACK -- requirements
Module: rx_unpack

Interface
REQ-001 SHALL have parameter MAC_TYPE, default 16'h0800, the required Ethernet type.
REQ-002 SHALL have parameter IP_PRL, default 8'd17, the required IP protocol (UDP).
REQ-003 SHALL have parameter ACPT_BCAST, default 1, which accepts destination MAC 48'hFFFF_FFFF_FFFF when set.
REQ-004 SHALL have ports: clk in 1 clock; rst_n in 1 asynchronous active-low reset.
REQ-005 SHALL have ports: cfg_mac_d in 48 own MAC; cfg_dip in 32 own IP; cfg_dport in 16 own UDP port.
REQ-006 SHALL have ports: rx_data in 16; rx_sop in 1; rx_eop in 1; rx_vld in 1; rx_mty in 1 (last beat holds only the [15:8] byte); rx_rdy out 1.
REQ-007 SHALL have ports: dout out 16; dout_sop out 1; dout_eop out 1; dout_vld out 1; dout_mty out 1; dout_rdy in 1.
REQ-008 SHALL have ports: pkt_drop out 1 drop pulse; drop_code out 3 reason; pkt_sip out 32 and pkt_sport out 16, the source IP and source port of the last accepted packet.

Function
REQ-009 SHALL drive rx_rdy combinationally equal to dout_rdy; a beat is accepted when rx_vld && rx_rdy.
REQ-010 SHALL implement states IDLE, HEAD, DATA, DISC.
REQ-011 SHALL leave IDLE only on an accepted beat with rx_sop=1, which is header word 0, moving to HEAD; accepted beats without sop in IDLE SHALL be ignored.
REQ-012 SHALL ignore rx_sop outside IDLE and treat such a beat as an ordinary beat.
REQ-013 SHALL number header words 0..20 with a 5-bit counter: 0-2 dst MAC, 3-5 src MAC, 6 type, 7-16 IP header, 17 sport, 18 dport, 19 UDP length, 20 UDP checksum (not verified).
REQ-014 SHALL accumulate the one's-complement sum of words 7..16 with end-around carry, one word per beat; the IP checksum is valid iff the final sum is 16'hFFFF.
REQ-015 SHALL check: code 1 dst MAC differs from cfg_mac_d and is not an accepted broadcast; 2 type != MAC_TYPE; 3 word 7[15:8] != 8'h45 or word 11[7:0] != IP_PRL; 4 IP checksum invalid; 5 dst IP (words 15-16) != cfg_dip; 6 dport != cfg_dport; 7 UDP length < 9 or rx_eop during HEAD.
REQ-016 SHALL report the lowest failing code when more than one check fails.
REQ-017 SHALL pulse pkt_drop for one cycle, with drop_code valid in that cycle, one cycle after the deciding beat; drop_code SHALL hold its value until the next drop.
REQ-018 SHALL decide at header word 20: pass moves to DATA and loads pkt_sip and pkt_sport; fail moves to DISC.
REQ-019 SHALL treat rx_eop in HEAD as an immediate drop with code 7 and a return to IDLE.
REQ-020 SHALL, in DATA, use payload length L = udp_len - 8 bytes and beat count N = ceil(L/2), tracked by a 16-bit down-counter.
REQ-021 SHALL copy payload beat k (k = 1..N) to dout one cycle after acceptance, with dout_vld=1, dout_sop=1 on k=1, and dout_eop=1 with dout_mty=L[0] on k=N.
REQ-022 SHALL swallow accepted beats after N (Ethernet padding) until rx_eop, then return to IDLE.
REQ-023 SHALL, if rx_eop arrives in DATA at beat k<N, output that beat with dout_eop=1 and dout_mty=rx_mty, then pulse pkt_drop with code 7 in the same cycle as that dout_eop, and return to IDLE.
REQ-024 SHALL, when beat N carries rx_eop, return to IDLE directly.
REQ-025 SHALL, in DISC, discard beats until an accepted rx_eop, then return to IDLE; dout_vld SHALL stay 0.
REQ-026 SHALL assert dout_vld for exactly one cycle per emitted beat; the downstream must absorb any beat presented one cycle after it drove dout_rdy=1.
REQ-027 SHALL leave all state unchanged on cycles with no accepted beat.

Reset
REQ-028 SHALL, while rst_n=0, force: state IDLE; counters 0; dout 0; dout_sop, dout_eop, dout_vld, dout_mty, pkt_drop 0; drop_code 0; pkt_sip 0; pkt_sport 0.
REQ-029 SHALL, when reset is asserted mid-packet, discard the remainder of that packet, since it carries no sop, with no output and no drop pulse.

Verification
REQ-030 Valid frame, udp_len=13 (L=5), 3 payload beats -> 3 dout_vld pulses, sop on beat 1, eop with mty=1 on beat 3, pkt_drop=0.
REQ-031 Frame with a corrupted IP checksum word -> pkt_drop pulse with drop_code=4, no dout_vld, next valid frame passes.
REQ-032 Wrong dst MAC and wrong dport together -> drop_code=1.
REQ-033 udp_len=10 (L=2) with 18 payload bytes incl. padding -> one dout beat with sop=eop=1, mty=0; padding beats swallowed.
REQ-034 rx_eop at header word 12 -> drop_code=7, state IDLE, back-to-back next frame accepted.
REQ-035 dout_rdy toggled 1/0 every cycle on a valid 8-byte payload -> rx_rdy follows dout_rdy, exactly 4 dout beats, data order intact.

Source files
------------

// File: rtl/rx_unpack.sv
// Receive-side Ethernet/IPv4/UDP header filter: checks the 21-word header,
// forwards the UDP payload on a match and reports a coded drop otherwise.
module rx_unpack #(
  parameter logic [15:0] MAC_TYPE   = 16'h0800,
  parameter logic [7:0]  IP_PRL     = 8'd17,
  parameter bit          ACPT_BCAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] cfg_mac_d,
  input  logic [31:0] cfg_dip,
  input  logic [15:0] cfg_dport,
  input  logic [15:0] rx_data,
  input  logic        rx_sop,
  input  logic        rx_eop,
  input  logic        rx_vld,
  input  logic        rx_mty,
  output logic        rx_rdy,
  output logic [15:0] dout,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        dout_vld,
  output logic        dout_mty,
  input  logic        dout_rdy,
  output logic        pkt_drop,
  output logic [2:0]  drop_code,
  output logic [31:0] pkt_sip,
  output logic [15:0] pkt_sport
);

  localparam int unsigned DW = 16;
  localparam int unsigned HW = 5;

  typedef enum logic [1:0] {IDLE, HEAD, DATA, DISC} state_t;

  state_t          r_state,  w_state_nxt;
  logic [HW-1:0]   r_hcnt,   w_hcnt_nxt;
  logic [7:1]      r_err,    w_err_nxt;
  logic            r_mac_ne, w_mac_ne_nxt;
  logic            r_bc_ne,  w_bc_ne_nxt;
  logic [DW-1:0]   r_csum,   w_csum_nxt;
  logic [31:0]     r_sip_t,  w_sip_t_nxt;
  logic [DW-1:0]   r_sport_t, w_sport_t_nxt;
  logic [DW-1:0]   r_len,    w_len_nxt;
  logic [DW-1:0]   r_bcnt,   w_bcnt_nxt;
  logic            r_first,  w_first_nxt;
  logic            r_lpar,   w_lpar_nxt;
  logic [DW-1:0]   r_dout,   w_dout_nxt;
  logic            r_sop,    w_sop_nxt;
  logic            r_eop,    w_eop_nxt;
  logic            r_vld,    w_vld_nxt;
  logic            r_mty,    w_mty_nxt;
  logic            r_drop,   w_drop_nxt;
  logic [2:0]      r_code,   w_code_nxt;
  logic [31:0]     r_sip,    w_sip_nxt;
  logic [DW-1:0]   r_sport,  w_sport_nxt;

  logic            w_acc;
  logic [HW-1:0]   w_idx;
  logic [DW:0]     w_csum_sum;
  logic [DW-1:0]   w_csum_add;
  logic [DW-1:0]   w_mac_word;

  function automatic logic [2:0] f_lowest(input logic [7:1] e);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (e[i]) c = 3'(i);
    end
    return c;
  endfunction

  assign rx_rdy = dout_rdy;
  assign w_acc  = rx_vld && dout_rdy;
  assign w_idx  = (r_state == IDLE) ? HW'(0) : r_hcnt;

  // One's-complement add with end-around carry
  assign w_csum_sum = {1'b0, r_csum} + {1'b0, rx_data};
  assign w_csum_add = w_csum_sum[DW-1:0] + DW'(w_csum_sum[DW]);

  always_comb begin
    w_mac_word = cfg_mac_d[15:0];
    case (w_idx)
      5'd0:    w_mac_word = cfg_mac_d[47:32];
      5'd1:    w_mac_word = cfg_mac_d[31:16];
      default: w_mac_word = cfg_mac_d[15:0];
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_hcnt_nxt    = r_hcnt;
    w_err_nxt     = r_err;
    w_mac_ne_nxt  = r_mac_ne;
    w_bc_ne_nxt   = r_bc_ne;
    w_csum_nxt    = r_csum;
    w_sip_t_nxt   = r_sip_t;
    w_sport_t_nxt = r_sport_t;
    w_len_nxt     = r_len;
    w_bcnt_nxt    = r_bcnt;
    w_first_nxt   = r_first;
    w_lpar_nxt    = r_lpar;
    w_dout_nxt    = r_dout;
    w_sop_nxt     = 1'b0;
    w_eop_nxt     = 1'b0;
    w_vld_nxt     = 1'b0;
    w_mty_nxt     = 1'b0;
    w_drop_nxt    = 1'b0;
    w_code_nxt    = r_code;
    w_sip_nxt     = r_sip;
    w_sport_nxt   = r_sport;

    case (r_state)
      IDLE, HEAD: begin
        if (w_acc && (r_state == HEAD || rx_sop)) begin
          if (r_state == IDLE) begin
            w_err_nxt    = '0;
            w_mac_ne_nxt = 1'b0;
            w_bc_ne_nxt  = 1'b0;
            w_csum_nxt   = '0;
          end
          if (w_idx >= 5'd7 && w_idx <= 5'd16) w_csum_nxt = w_csum_add;
          case (w_idx)
            5'd0, 5'd1, 5'd2: begin
              w_mac_ne_nxt = w_mac_ne_nxt | (rx_data != w_mac_word);
              w_bc_ne_nxt  = w_bc_ne_nxt | (rx_data != 16'hFFFF);
              if (w_idx == 5'd2)
                w_err_nxt[1] = w_mac_ne_nxt && !(ACPT_BCAST && !w_bc_ne_nxt);
            end
            5'd6:  w_err_nxt[2] = (rx_data != MAC_TYPE);
            5'd7:  w_err_nxt[3] = r_err[3] | (rx_data[15:8] != 8'h45);
            5'd11: w_err_nxt[3] = r_err[3] | (rx_data[7:0] != IP_PRL);
            5'd13: w_sip_t_nxt[31:16] = rx_data;
            5'd14: w_sip_t_nxt[15:0]  = rx_data;
            5'd15: w_err_nxt[5] = (rx_data != cfg_dip[31:16]);
            5'd16: begin
              w_err_nxt[5] = r_err[5] | (rx_data != cfg_dip[15:0]);
              w_err_nxt[4] = (w_csum_add != 16'hFFFF);
            end
            5'd17: w_sport_t_nxt = rx_data;
            5'd18: w_err_nxt[6] = (rx_data != cfg_dport);
            5'd19: begin
              w_err_nxt[7] = (rx_data < 16'd9);
              w_len_nxt    = rx_data;
            end
            default: ;
          endcase
          w_hcnt_nxt = w_idx + HW'(1);
          // A truncated header is dropped and leaves the FSM ready for a new sop
          if (rx_eop) begin
            w_err_nxt[7] = 1'b1;
            w_drop_nxt   = 1'b1;
            w_code_nxt   = f_lowest(w_err_nxt);
            w_state_nxt  = IDLE;
          end else if (w_idx == 5'd20) begin
            if (w_err_nxt == '0) begin
              w_state_nxt = DATA;
              w_bcnt_nxt  = DW'((r_len - 16'd7) >> 1);
              w_lpar_nxt  = r_len[0];
              w_first_nxt = 1'b1;
              w_sip_nxt   = r_sip_t;
              w_sport_nxt = r_sport_t;
            end else begin
              w_drop_nxt  = 1'b1;
              w_code_nxt  = f_lowest(w_err_nxt);
              w_state_nxt = DISC;
            end
          end else begin
            w_state_nxt = HEAD;
          end
        end
      end
      DATA: begin
        if (w_acc) begin
          // Zero remaining count means the beat is Ethernet padding
          if (r_bcnt != '0) begin
            w_dout_nxt  = rx_data;
            w_vld_nxt   = 1'b1;
            w_sop_nxt   = r_first;
            w_first_nxt = 1'b0;
            w_bcnt_nxt  = r_bcnt - DW'(1);
            if (r_bcnt == DW'(1)) begin
              w_eop_nxt = 1'b1;
              w_mty_nxt = r_lpar;
              if (rx_eop) w_state_nxt = IDLE;
            end else if (rx_eop) begin
              w_eop_nxt   = 1'b1;
              w_mty_nxt   = rx_mty;
              w_drop_nxt  = 1'b1;
              w_code_nxt  = 3'd7;
              w_state_nxt = IDLE;
            end
          end else if (rx_eop) begin
            w_state_nxt = IDLE;
          end
        end
      end
      DISC: begin
        if (w_acc && rx_eop) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_hcnt    <= '0;
      r_err     <= '0;
      r_mac_ne  <= 1'b0;
      r_bc_ne   <= 1'b0;
      r_csum    <= '0;
      r_sip_t   <= '0;
      r_sport_t <= '0;
      r_len     <= '0;
      r_bcnt    <= '0;
      r_first   <= 1'b0;
      r_lpar    <= 1'b0;
      r_dout    <= '0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_vld     <= 1'b0;
      r_mty     <= 1'b0;
      r_drop    <= 1'b0;
      r_code    <= '0;
      r_sip     <= '0;
      r_sport   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_err     <= w_err_nxt;
      r_mac_ne  <= w_mac_ne_nxt;
      r_bc_ne   <= w_bc_ne_nxt;
      r_csum    <= w_csum_nxt;
      r_sip_t   <= w_sip_t_nxt;
      r_sport_t <= w_sport_t_nxt;
      r_len     <= w_len_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_first   <= w_first_nxt;
      r_lpar    <= w_lpar_nxt;
      r_dout    <= w_dout_nxt;
      r_sop     <= w_sop_nxt;
      r_eop     <= w_eop_nxt;
      r_vld     <= w_vld_nxt;
      r_mty     <= w_mty_nxt;
      r_drop    <= w_drop_nxt;
      r_code    <= w_code_nxt;
      r_sip     <= w_sip_nxt;
      r_sport   <= w_sport_nxt;
    end
  end

  assign dout      = r_dout;
  assign dout_sop  = r_sop;
  assign dout_eop  = r_eop;
  assign dout_vld  = r_vld;
  assign dout_mty  = r_mty;
  assign pkt_drop  = r_drop;
  assign drop_code = r_code;
  assign pkt_sip   = r_sip;
  assign pkt_sport = r_sport;

endmodule
